// File: rtl/div_pkg.sv
// Shared constants and result type for the divider result path.
package div_pkg;

    localparam int DIV_DW = 10;

    localparam logic [1:0] STAT_OK  = 2'b00;
    localparam logic [1:0] STAT_OVF = 2'b01;
    localparam logic [1:0] STAT_DVZ = 2'b10;

    localparam logic [DIV_DW-1:0] OVF_FILL = {DIV_DW{1'b1}};

    typedef struct packed {
        logic [DIV_DW-1:0] data;
        logic [1:0]        status;
    } div_result_t;

endpackage

// File: rtl/div_result_buffer_if.sv
// Divider-side capture, consumer handshake and error-statistics signals of the result buffer.
interface div_result_buffer_if
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int CW = 8
);
    logic          div_done;
    logic [DW-1:0] quotient;
    logic          ovf;
    logic          dvz;
    logic          hold;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [1:0]    res_status;
    logic [CW-1:0] err_count;
    logic          overrun;
    logic          clr_err;

    // master drives the divider side and consumes results; slave is the buffer
    modport master (
        output div_done, quotient, ovf, dvz, res_ready, clr_err,
        input  hold, res_valid, res_data, res_status, err_count, overrun
    );

    modport slave (
        input  div_done, quotient, ovf, dvz, res_ready, clr_err,
        output hold, res_valid, res_data, res_status, err_count, overrun
    );
endinterface

// File: rtl/res_fifo_core.sv
// First-word-fall-through storage: DEPTH entries of W bits, pointers plus occupancy count.
module res_fifo_core #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         sclr_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/div_result_buffer.sv
// Captures divider results, encodes status, queues them for the consumer and keeps error statistics.
module div_result_buffer
    import div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DIV_DW,
    parameter int CW    = 8
) (
    input logic               clk,
    input logic               sclr_n,
    div_result_buffer_if.slave bus
);
    logic [DW-1:0]   w_enc_data;
    logic [1:0]      w_enc_stat;
    logic [DW+1:0]   w_fifo_dout;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [CW-1:0]   w_err_next;
    logic            w_ovr_next;
    logic [CW-1:0]   r_err_count;
    logic            r_overrun;

    // dvz outranks ovf; inputs are don't-care outside a done pulse
    always_comb begin
        w_enc_data = '0;
        w_enc_stat = STAT_OK;
        if (bus.div_done) begin
            if (bus.dvz) begin
                w_enc_data = '0;
                w_enc_stat = STAT_DVZ;
            end else if (bus.ovf) begin
                w_enc_data = {DW{1'b1}};
                w_enc_stat = STAT_OVF;
            end else begin
                w_enc_data = bus.quotient;
                w_enc_stat = STAT_OK;
            end
        end
    end

    assign w_pop  = !w_empty && bus.res_ready;
    assign w_push = bus.div_done && (!w_full || w_pop);
    assign w_drop = bus.div_done && w_full && !w_pop;

    res_fifo_core #(
        .DEPTH (DEPTH),
        .W     (DW + 2)
    ) u_fifo (
        .clk     (clk),
        .sclr_n  (sclr_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({w_enc_data, w_enc_stat}),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Clear is applied before the increment, so a clear plus error push lands on 1.
    always_comb begin
        w_err_next = bus.clr_err ? '0 : r_err_count;
        if (w_push && (w_enc_stat != STAT_OK) && (w_err_next != {CW{1'b1}})) begin
            w_err_next = w_err_next + CW'(1);
        end
        w_ovr_next = bus.clr_err ? 1'b0 : r_overrun;
        if (w_drop) begin
            w_ovr_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            r_err_count <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_err_count <= w_err_next;
            r_overrun   <= w_ovr_next;
        end
    end

    assign bus.res_valid  = !w_empty;
    assign bus.res_data   = w_empty ? '0 : w_fifo_dout[DW+1:2];
    assign bus.res_status = w_empty ? STAT_OK : w_fifo_dout[1:0];
    assign bus.hold       = w_full;
    assign bus.err_count  = r_err_count;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_div_result_buffer.sv
// Scoreboard bench for div_result_buffer: queue-based reference model, directed plus random stimulus.
module tb_div_result_buffer;
    import div_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 10;
    localparam int CW    = 8;
    localparam int ERR_MAX = (1 << CW) - 1;

    logic clk;
    logic sclr_n;

    div_result_buffer_if #(.DW(DW), .CW(CW)) bus ();

    div_result_buffer #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk    (clk),
        .sclr_n (sclr_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of expected {status, data} entries, plus statistics.
    logic [DW+1:0] m_q[$];
    int            m_err;
    bit            m_ovr;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW+1:0] enc(input logic [DW-1:0] q, input bit o, input bit z);
        if (z)      return {STAT_DVZ, {DW{1'b0}}};
        else if (o) return {STAT_OVF, OVF_FILL};
        else        return {STAT_OK, q};
    endfunction

    // Monitor: compare DUT against model, then advance the model by the coming edge.
    always @(negedge clk) begin
        logic [DW+1:0] head;
        bit pop;
        bit full;
        if (!sclr_n) begin
            m_q.delete();
            m_err = 0;
            m_ovr = 0;
        end
        chk("res_valid", int'(bus.res_valid), int'(m_q.size() != 0));
        chk("hold", int'(bus.hold), int'(m_q.size() == DEPTH));
        chk("err_count", int'(bus.err_count), m_err);
        chk("overrun", int'(bus.overrun), int'(m_ovr));
        head = (m_q.size() != 0) ? m_q[0] : '0;
        if (bus.res_valid && bus.res_ready) begin
            chk("res_data", int'(bus.res_data), int'(head[DW-1:0]));
            chk("res_status", int'(bus.res_status), int'(head[DW+1:DW]));
        end else if (!bus.res_valid) begin
            chk("idle_data", int'(bus.res_data), 0);
            chk("idle_status", int'(bus.res_status), 0);
        end
        if (sclr_n) begin
            pop  = (m_q.size() != 0) && bus.res_ready;
            full = (m_q.size() == DEPTH);
            if (bus.clr_err) begin
                m_err = 0;
                m_ovr = 0;
            end
            if (pop) void'(m_q.pop_front());
            if (bus.div_done) begin
                if (!full || pop) begin
                    m_q.push_back(enc(bus.quotient, bus.ovf, bus.dvz));
                    if ((bus.dvz || bus.ovf) && m_err < ERR_MAX) m_err++;
                end else begin
                    m_ovr = 1;
                end
            end
        end
    end

    task automatic drive(input bit dd, input logic [DW-1:0] q, input bit o, input bit z,
                         input bit r, input bit c);
        bus.div_done  = dd;
        bus.quotient  = q;
        bus.ovf       = o;
        bus.dvz       = z;
        bus.res_ready = r;
        bus.clr_err   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.div_done  = 0;
        bus.quotient  = '0;
        bus.ovf       = 0;
        bus.dvz       = 0;
        bus.res_ready = 0;
        bus.clr_err   = 0;
        sclr_n        = 0;
        repeat (2) @(posedge clk);
        #1 sclr_n = 1;
        drive(0, '0, 0, 0, 0, 0);

        // single clean result, then pop
        drive(1, 10'h00C, 0, 0, 0, 0);
        drive(0, '0, 0, 0, 0, 0);
        drive(0, '0, 0, 0, 1, 0);
        drive(0, '0, 0, 0, 0, 0);

        // ovf, dvz-over-ovf, clean, continuously consumed
        drive(1, 10'h2A5, 1, 0, 1, 0);
        drive(1, 10'h155, 1, 1, 1, 0);
        drive(1, 10'h001, 0, 0, 1, 0);
        repeat (3) drive(0, '0, 0, 0, 1, 0);
        chk("err_after_mix", int'(bus.err_count), 2);

        // five pushes into a 4-deep FIFO without consumption
        for (int i = 0; i < 5; i++) drive(1, 10'(i + 16), 0, 0, 0, 0);
        chk("hold_full", int'(bus.hold), 1);
        chk("overrun_drop", int'(bus.overrun), 1);
        repeat (5) drive(0, '0, 0, 0, 1, 0);
        drive(0, '0, 0, 0, 0, 1);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) drive(1, 10'(i + 32), 0, 0, 0, 0);
        drive(1, 10'h0AA, 0, 0, 1, 0);
        drive(0, '0, 0, 0, 0, 0);
        chk("hold_after_swap", int'(bus.hold), 1);
        chk("overrun_swap", int'(bus.overrun), 0);
        chk("head_after_swap", int'(bus.res_data), 33);
        repeat (5) drive(0, '0, 0, 0, 1, 0);

        // saturation, then clear coinciding with a dvz push
        for (int i = 0; i < 260; i++) drive(1, 10'($urandom), 1, 0, 1, 0);
        chk("err_saturated", int'(bus.err_count), ERR_MAX);
        drive(1, 10'h123, 0, 1, 1, 1);
        chk("err_clr_push", int'(bus.err_count), 1);
        chk("ovr_clr_push", int'(bus.overrun), 0);
        repeat (2) drive(0, '0, 0, 0, 1, 0);

        // asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) drive(1, 10'(i + 64), i == 1, 0, 0, 0);
        drive(0, '0, 0, 0, 0, 0);
        #2 sclr_n = 0;
        #1;
        chk("async_valid", int'(bus.res_valid), 0);
        chk("async_hold", int'(bus.hold), 0);
        chk("async_err", int'(bus.err_count), 0);
        @(posedge clk);
        #1 sclr_n = 1;
        drive(1, 10'h3C3, 0, 0, 0, 0);
        drive(0, '0, 0, 0, 0, 0);
        chk("post_reset_data", int'(bus.res_data), 10'h3C3);
        drive(0, '0, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 1) == 1, 10'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 49) == 0);
        end
        repeat (6) drive(0, '0, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_result_buffer.md
Name: div_result_buffer

Overview:
- Downstream stage of the 10-bit sequential divider datapath/controller pair.
- Captures each finished division: quotient plus ovf/dvz flags, on the controller's done pulse.
- Encodes a status code and queues results in a small first-word-fall-through FIFO.
- Delivers results to the consumer over a valid/ready handshake; backpressures the divider controller when full and keeps saturating error statistics.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DW, 10, quotient width; matches divider quotient.
- CW, 8, error-counter width.

Ports:
- clk  in  1  rising-edge clock
- sclr_n  in  1  reset; one clock; reset is asynchronous and active-low
- div_done  in  1  one-cycle pulse from divider controller; quotient/ovf/dvz valid in the same cycle
- quotient  in  DW  divider quotient
- ovf  in  1  divider overflow flag
- dvz  in  1  divide-by-zero flag
- hold  out  1  high when FIFO full; controller must not start a new division
- res_valid  out  1  head entry available
- res_ready  in  1  consumer accepts head entry
- res_data  out  DW  head entry data
- res_status  out  2  head entry status: 00 OK, 01 OVF, 10 DVZ
- err_count  out  CW  saturating count of accepted OVF/DVZ results
- overrun  out  1  sticky: a div_done arrived while full and was dropped
- clr_err  in  1  synchronous clear of err_count and overrun

Behaviour:
- Reset (sclr_n low, async): FIFO emptied (wr_ptr = rd_ptr = count = 0), res_valid = 0, hold = 0, res_data = 0, res_status = 00, err_count = 0, overrun = 0. Reset mid-operation discards all entries immediately.
- Entry encoding at push:
  - dvz = 1: status 10, data forced to 0. dvz has priority over ovf.
  - else ovf = 1: status 01, data forced to all-ones (10'h3FF).
  - else: status 00, data = quotient.
- Push: div_done = 1 and (count < DEPTH, or pop in the same cycle). Write at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: res_valid & res_ready. rd_ptr increments modulo DEPTH.
- count next state:
  - push only: +1
  - pop only: −1
  - both: unchanged, including when full (simultaneous push+pop while full is accepted).
  - push on empty + simultaneous res_ready: no pop, since res_valid is 0 that cycle.
- Drop: div_done while count == DEPTH and no pop that cycle. Entry discarded, overrun set to 1, err_count unchanged.
- Output timing (first-word fall-through): res_valid = (count != 0). res_data/res_status come from storage[rd_ptr], driven from registers. A result pushed at edge N is visible with res_valid = 1 from edge N onward (one-cycle latency from div_done).
- While res_valid = 0: res_data = 0 and res_status = 00.
- Holding: res_data/res_status stable while res_valid & !res_ready.
- hold = (count == DEPTH), registered; asserted in the cycle after the push that fills the FIFO.
- err_count: +1 on each accepted push with status != 00; saturates at 2^CW−1.
- clr_err: zeroes err_count and overrun. If clr_err coincides with an error push, the result is err_count = 1 (the clear applies first, then the increment). The same ordering applies to overrun.
- Pointers: log2(DEPTH) bits plus a separate count register of log2(DEPTH)+1 bits. Wrap-around is natural modulo.
- X-safety: quotient/ovf/dvz are ignored when div_done = 0.

Decomposition:
- Shared package div_pkg:
  - constants DIV_DW = 10, STAT_OK = 2'b00, STAT_OVF = 2'b01, STAT_DVZ = 2'b10
  - OVF_FILL = all-ones of DIV_DW
  - typedef div_result_t {data[DW], status[2]}
- Sub-module res_fifo_core: parameterised DEPTH×(DW+2) storage, pointers, count, full/empty. Top level holds encoding, error statistics and overrun logic.

Test Plan:
- Reset, then div_done with quotient = 10'h00C, ovf = 0, dvz = 0 -> next cycle res_valid = 1, res_data = 10'h00C, res_status = 00. Pop clears res_valid.
- Push ovf = 1 (quotient 10'h2A5), then dvz = 1 with ovf = 1, then clean 10'h001, res_ready = 1 -> outputs in order: (10'h3FF, 01), (10'h000, 10), (10'h001, 00); err_count = 2.
- res_ready = 0, five pushes with DEPTH = 4 -> hold = 1 after 4th push; 5th dropped; overrun = 1; draining yields the first four values in order.
- FIFO full, div_done and res_ready in the same cycle -> count stays 4, head advances, new entry appears last; overrun stays 0.
- 260 consecutive ovf pushes with continuous pop -> err_count saturates at 255. clr_err pulse coinciding with a dvz push -> err_count = 1, overrun = 0.
- Assert sclr_n low asynchronously mid-cycle with 3 entries queued -> res_valid, hold, err_count drop to 0 immediately, without waiting for a clk edge; first push after release appears normally.
